// File: rtl/ext_pkg.sv
// Mode encodings shared by the immediate/target generator and its decoder.
package ext_pkg;

  localparam int unsigned EXT_MODE_W = 3;

  localparam logic [EXT_MODE_W-1:0] EXT_SEXT     = 3'd0;
  localparam logic [EXT_MODE_W-1:0] EXT_ZEXT     = 3'd1;
  localparam logic [EXT_MODE_W-1:0] EXT_LUI      = 3'd2;
  localparam logic [EXT_MODE_W-1:0] EXT_SEXT_SHL = 3'd3;
  localparam logic [EXT_MODE_W-1:0] EXT_BRANCH   = 3'd4;
  localparam logic [EXT_MODE_W-1:0] EXT_JUMP     = 3'd5;

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready buffer. in_ready comes straight from a flop so no
// combinational path runs from out_ready back to the producer.
module skid_buf #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e       state_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_ready_q;
  logic         accept;

  assign accept = in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      // Squash wins over any same-cycle accept or consume.
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q  <= in_data;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (accept && out_ready) begin
            main_q <= in_data;
          end else if (accept) begin
            skid_q     <= in_data;
            state_q    <= StTwo;
            in_ready_q <= 1'b0;
          end else if (out_ready) begin
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          if (out_ready) begin
            main_q     <= skid_q;
            state_q    <= StOne;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= StEmpty;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;

endmodule

// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate / branch / jump target generator with a registered
// two-entry output buffer and synchronous flush.
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned JIDX_W = 26,
  parameter int unsigned SHAMT  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXT_MODE_W-1:0] in_mode,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic [JIDX_W-1:0]     in_jidx,
  input  logic [DATA_W-1:0]     in_pc4,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_err
);

  if (IMM_W > DATA_W) begin : gen_bad_imm_w
    $error("imm_ext_pipe: IMM_W must not exceed DATA_W");
  end
  if (JIDX_W + SHAMT > DATA_W) begin : gen_bad_jidx_w
    $error("imm_ext_pipe: JIDX_W + SHAMT must not exceed DATA_W");
  end

  // Bits of the target supplied by jidx and the shift; the rest come from pc4.
  localparam logic [DATA_W-1:0] JumpLowMask = {DATA_W{1'b1}} >> (DATA_W - JIDX_W - SHAMT);

  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] sext_shl;
  logic [DATA_W-1:0] res;
  logic              res_err;
  logic [DATA_W:0]   buf_out;

  assign sext     = DATA_W'(signed'(in_imm));
  assign zext     = DATA_W'(in_imm);
  assign sext_shl = sext << SHAMT;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (in_mode)
      EXT_SEXT:     res = sext;
      EXT_ZEXT:     res = zext;
      EXT_LUI:      res = zext << (DATA_W - IMM_W);
      EXT_SEXT_SHL: res = sext_shl;
      EXT_BRANCH:   res = in_pc4 + sext_shl;
      EXT_JUMP:     res = (in_pc4 & ~JumpLowMask) | (DATA_W'(in_jidx) << SHAMT);
      default: begin
        res     = '0;
        res_err = 1'b1;
      end
    endcase
  end

  skid_buf #(
    .W(DATA_W + 1)
  ) u_skid_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({res_err, res}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out)
  );

  assign out_err  = buf_out[DATA_W];
  assign out_data = buf_out[DATA_W-1:0];

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate and target generator for the decode stage of the MIPS32 core. It takes the I-type immediate, the J-type index and the incremented PC, and produces one DATA_W-bit operand per transaction. Supported modes are sign-extend, zero-extend, upper-load, shifted sign-extend, branch target and jump target. A valid/ready handshake with a two-entry skid buffer lets decode stall without losing operands, and a synchronous flush squashes in-flight results on a redirect.

## Interface
- DATA_W, 32: output and PC width.
- IMM_W, 16: immediate field width; must satisfy IMM_W ≤ DATA_W.
- JIDX_W, 26: jump index width; must satisfy JIDX_W + SHAMT ≤ DATA_W.
- SHAMT, 2: left-shift amount for the shifted, branch and jump modes.
- clk, in, 1: single clock; all state changes on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: input transaction present.
- in_ready, out, 1: block can accept a transaction this cycle.
- in_mode, in, 3: operation select (encodings under Operation).
- in_imm, in, IMM_W: immediate field.
- in_jidx, in, JIDX_W: jump index field.
- in_pc4, in, DATA_W: PC+4 of the instruction.
- flush, in, 1: synchronous squash of all held results.
- out_valid, out, 1: out_data and out_err are valid.
- out_ready, in, 1: consumer accepts the output this cycle.
- out_data, out, DATA_W: result.
- out_err, out, 1: result was produced from an illegal mode.

## Operation
- Let S = in_imm sign-extended to DATA_W.
- Mode encodings and results:
  - SEXT (0): S.
  - ZEXT (1): in_imm zero-extended.
  - LUI (2): in_imm placed in the top IMM_W bits; lower bits are zero.
  - SEXT_SHL (3): S << SHAMT. The shift applies to the freshly extended value, never to a previous result.
  - BRANCH (4): in_pc4 + (S << SHAMT), modulo 2^DATA_W. Carry-out is discarded.
  - JUMP (5): in_pc4[DATA_W-1 : JIDX_W+SHAMT] concatenated with in_jidx and SHAMT zero bits.
  - Modes 6 and 7: result is 0 and out_err = 1.
- out_err = 0 for all legal modes.
- Result computation is combinational. The output is held in a registered skid buffer with a main entry and a skid entry.
- A transaction is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- in_ready = !skid_full. in_ready is driven directly from a register, with no combinational path from out_ready.
- Buffer states:
  - EMPTY: out_valid = 0.
  - ONE: main entry full.
  - TWO: main and skid entries full.
- Transitions, when flush = 0:
  - EMPTY + accept → ONE.
  - ONE + accept, no consume → TWO.
  - ONE + consume, no accept → EMPTY.
  - ONE + accept + consume → ONE; main entry takes the new result.
  - TWO + consume → ONE; the skid entry moves to main. No accept is possible in TWO.
- flush = 1: next state is EMPTY and any accept in the same cycle is dropped. Flush has priority over every other event.
- Ordering is strictly FIFO, and no result is ever duplicated or lost without a flush.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_err = 0, in_ready = 1, state EMPTY.
- Reset takes effect asynchronously on assertion. Release is clean, and the block can accept in the first cycle after release.
- Latency: an input accepted at edge N appears with out_valid = 1 after edge N.
- Throughput: one transaction per cycle while out_ready stays high.
- When out_ready falls, at most one further input is absorbed into the skid entry. in_ready drops the cycle after the buffer reaches TWO.
- While out_valid = 1 && out_ready = 0, out_data and out_err are stable.
- Flush at edge N gives out_valid = 0 and in_ready = 1 after N.
- Reset asserted mid-transaction discards all entries with no residual output.

## Structure
- Package ext_pkg holds:
  - the 3-bit mode encodings: EXT_SEXT, EXT_ZEXT, EXT_LUI, EXT_SEXT_SHL, EXT_BRANCH, EXT_JUMP;
  - the mode width constant, 3.
- The decoder imports ext_pkg.
- Sub-module skid_buf (parameter W) implements the two-entry handshake buffer.
- imm_ext_pipe instantiates skid_buf with W = DATA_W + 1 (data plus err). The result mux stays in the top level.
- Elaboration fails on any parameter-constraint violation.

## Test plan
- SEXT with imm 16'hFABC → 32'hFFFF_FABC. ZEXT with the same imm → 32'h0000_FABC. LUI with the same imm → 32'hFABC_0000. Each appears one cycle after accept.
- SEXT_SHL with imm 16'h8001 → 32'hFFFE_0004. BRANCH with pc4 32'h0040_0010 and imm 16'hFFFF → 32'h0040_000C. JUMP with pc4 32'h9000_0000 and jidx 26'h0000_100 → 32'h9000_0400.
- BRANCH with pc4 32'hFFFF_FFFC and imm 16'h0001 → 32'h0000_0000, showing wrap-around with no error.
- Mode 3'b110 → out_data 0 with out_err 1. Next transaction, mode 0 with imm 1 → out_err 0.
- Back-to-back inputs with out_ready held low for 3 cycles:
  - only two transactions are accepted;
  - in_ready goes low;
  - after out_ready is raised, results emerge in order with no gaps or duplicates.
- flush asserted in TWO together with in_valid → next cycle out_valid 0, in_ready 1, and the dropped input never appears. rst_n pulsed low mid-stream → all outputs return to their reset values immediately.
